icache_fill_bridge: RTL

- Memory-side fill engine directly downstream of the read-only instruction cache.
- Accepts the cache's line-fill request (`i_mem_req`/`i_mem_addr`), issues pipelined sequential reads to a backing RAM port with arbitrary in-order latency, buffers returns in a small FIFO, and hands words back one per `o_mem_ack`.
- Ack is always coincident with the data for the word address currently presented by the cache.

---
 rtl/icache_fill_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/icache_fill_bridge.sv
// Line-fill engine between the instruction cache and a pipelined in-order RAM.
// Reads are credit-limited so the small return FIFO can never overflow.
`timescale 1ns/1ps
module icache_fill_bridge #(
   parameter  int unsigned BLOCK_WIDTH = 3,
   parameter  int unsigned FIFO_AW     = 2,
   localparam int unsigned AW          = 30,
   localparam int unsigned DW          = 32
) (
   input  logic          i_ck,
   input  logic          i_rb,
   input  logic          i_mem_req,
   input  logic [AW-1:0] i_mem_addr,
   output logic          o_mem_ack,
   output logic [DW-1:0] o_mem_data,
   output logic          o_ram_rd,
   output logic [AW-1:0] o_ram_addr,
   input  logic          i_ram_valid,
   input  logic [DW-1:0] i_ram_data,
   output logic          o_err
);

   localparam int unsigned BURST = 1 << BLOCK_WIDTH;
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = BLOCK_WIDTH + 1;
   localparam int unsigned FW    = FIFO_AW + 1;
   localparam int unsigned SW    = FW + 1;
   localparam int unsigned BW    = AW - BLOCK_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]      ret_cnt_q, ret_cnt_d;
   logic [FW-1:0]      inflight_q, inflight_d;
   logic [FW-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic [BW-1:0]      base_q, base_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic               err_q, err_d;
   logic [DW-1:0]      fifo_mem_q [DEPTH];

   logic          rd_c;
   logic          ack_c;
   logic          ret_accept_c;
   logic          push_c;
   logic          ret_done_c;
   logic          addr_bad_c;
   logic [SW-1:0] credit_sum_c;

   // Handshake decode: credit check, ack qualification and return acceptance.
   always_comb begin
      credit_sum_c = SW'(inflight_q) + SW'(fifo_cnt_q);
      rd_c         = (state_q == ISSUE) && (credit_sum_c < SW'(DEPTH));
      ack_c        = i_mem_req && (fifo_cnt_q != '0) &&
                     ((state_q == ISSUE) || (state_q == DRAIN));
      ret_accept_c = i_ram_valid && (inflight_q != '0);
      push_c       = ret_accept_c && (state_q != FLUSH);
      ret_done_c   = (ret_cnt_q == CW'(BURST));
      addr_bad_c   = (i_mem_addr[AW-1:BLOCK_WIDTH] != base_q) ||
                     (i_mem_addr[BLOCK_WIDTH-1:0] != ret_cnt_q[BLOCK_WIDTH-1:0]);
   end

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      inflight_d  = inflight_q;
      fifo_cnt_d  = fifo_cnt_q;
      base_d      = base_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      err_d       = err_q;

      if (rd_c) issue_cnt_d = issue_cnt_q + CW'(1);
      if (ack_c) ret_cnt_d = ret_cnt_q + CW'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (ack_c) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

      case ({rd_c, ret_accept_c})
         2'b10:   inflight_d = inflight_q + FW'(1);
         2'b01:   inflight_d = inflight_q - FW'(1);
         default: inflight_d = inflight_q;
      endcase

      case ({push_c, ack_c})
         2'b10:   fifo_cnt_d = fifo_cnt_q + FW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - FW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      if ((ack_c && addr_bad_c) || (i_ram_valid && (inflight_q == '0))) err_d = 1'b1;

      // Abort drops buffered words; reads already issued are drained in FLUSH.
      case (state_q)
         IDLE: begin
            if (i_mem_req) begin
               base_d      = i_mem_addr[AW-1:BLOCK_WIDTH];
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (!i_mem_req && !ret_done_c) begin
               state_d    = FLUSH;
               fifo_cnt_d = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
            end else if (rd_c && (issue_cnt_q == CW'(BURST - 1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ret_done_c) begin
               state_d = IDLE;
            end else if (!i_mem_req) begin
               state_d    = FLUSH;
               fifo_cnt_d = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
            end
         end
         FLUSH: begin
            if (inflight_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_ck or negedge i_rb) begin
      if (!i_rb) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         inflight_q  <= '0;
         fifo_cnt_q  <= '0;
         base_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         inflight_q  <= inflight_d;
         fifo_cnt_q  <= fifo_cnt_d;
         base_q      <= base_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         err_q       <= err_d;
      end
   end

   // Return storage; returns become visible one cycle after i_ram_valid.
   always_ff @(posedge i_ck or negedge i_rb) begin
      if (!i_rb) begin
         for (int i = 0; i < int'(DEPTH); i++) fifo_mem_q[i] <= '0;
      end else if (push_c) begin
         fifo_mem_q[wr_ptr_q] <= i_ram_data;
      end
   end

   assign o_ram_rd   = rd_c;
   assign o_ram_addr = rd_c ? {base_q, issue_cnt_q[BLOCK_WIDTH-1:0]} : '0;
   assign o_mem_ack  = ack_c;
   assign o_mem_data = ack_c ? fifo_mem_q[rd_ptr_q] : '0;
   assign o_err      = err_q;

endmodule
